// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: fetch port, data port and the shared memory command bus.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;

  logic        mem_re_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory; one access in flight.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of data-port priority.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        own_d;
  logic        own_we;
  logic        if_rv_q, d_rv_q;
  logic        any_req, pick_d, grant, last_beat;

  assign any_req = bus.if_req_i | bus.d_req_i;

`ifdef MEM_ARB_RR_EN
  // last_d = 1 when the data port won the most recent grant
  logic last_d;
  assign pick_d = bus.d_req_i & (~bus.if_req_i | ~last_d);

  always_ff @(posedge clk) begin
    if (rst)        last_d <= 1'b0;
    else if (grant) last_d <= pick_d;
  end
`else
  assign pick_d = bus.d_req_i;
`endif

  assign grant     = (state == IDLE) & any_req & ~rst;
  // Read data lands in the cycle the counter is about to reach zero
  assign last_beat = (state == WAIT) & (cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.if_gnt_o    = grant & ~pick_d;
    bus.d_gnt_o     = grant & pick_d;
    bus.mem_re_o    = (state == ISSUE) & ~own_we & ~rst;
    bus.mem_we_o    = (state == ISSUE) & own_we & ~rst;
    bus.if_rvalid_o = if_rv_q & ~rst;
    bus.d_rvalid_o  = d_rv_q & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= 4'd0;
      own_d           <= 1'b0;
      own_we          <= 1'b0;
      if_rv_q         <= 1'b0;
      d_rv_q          <= 1'b0;
      bus.if_rdata_o  <= 32'd0;
      bus.d_rdata_o   <= 32'd0;
      bus.mem_addr_o  <= 32'd0;
      bus.mem_wdata_o <= 32'd0;
      bus.mem_be_o    <= 4'd0;
    end else begin
      if_rv_q <= 1'b0;
      d_rv_q  <= 1'b0;

      if (grant) begin
        own_d  <= pick_d;
        own_we <= pick_d & bus.d_we_i;
        if (pick_d) begin
          bus.mem_addr_o  <= bus.d_addr_i;
          bus.mem_wdata_o <= bus.d_wdata_i;
          bus.mem_be_o    <= bus.d_be_i;
        end else begin
          bus.mem_addr_o  <= bus.if_addr_i;
          bus.mem_wdata_o <= 32'd0;
          bus.mem_be_o    <= 4'hF;
        end
      end

      if (state == ISSUE)     cnt <= 4'(MEM_LAT);
      else if (state == WAIT) cnt <= cnt - 4'd1;

      if (last_beat) begin
        if (own_d) begin
          d_rv_q <= 1'b1;
          // writes complete without touching the read-data register
          if (!own_we) bus.d_rdata_o <= bus.mem_rdata_i;
        end else begin
          if_rv_q        <= 1'b1;
          bus.if_rdata_o <= bus.mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles from the mem_re_o/mem_we_o cycle to the mem_rdata_i-valid cycle; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 if_req_i  input  1  instruction-fetch read request.
REQ-005 if_addr_i  input  32  fetch address; held stable by the requester until grant.
REQ-006 if_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid_o  output  1  one-cycle pulse; if_rdata_o valid.
REQ-008 if_rdata_o  output  32  fetch read data.
REQ-009 d_req_i  input  1  data-port request.
REQ-010 d_we_i  input  1  1 = write, 0 = read.
REQ-011 d_addr_i  input  32  data address.
REQ-012 d_wdata_i  input  32  write data.
REQ-013 d_be_i  input  4  write byte enables.
REQ-014 d_gnt_o  output  1  data request accepted this cycle.
REQ-015 d_rvalid_o  output  1  one-cycle pulse; read data valid, or write complete.
REQ-016 d_rdata_o  output  32  data read data.
REQ-017 mem_re_o / mem_we_o  output  1 each  one-cycle memory strobes.
REQ-018 mem_addr_o / mem_wdata_o / mem_be_o  output  32/32/4  registered memory command.
REQ-019 mem_rdata_i  input  32  memory read data, valid exactly MEM_LAT cycles after mem_re_o.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE, WAIT.
- IDLE: on any request, assert the winner's gnt combinationally in the same cycle, capture its command, go to ISSUE.
- ISSUE: drive mem_re_o or mem_we_o for exactly one cycle, load counter = MEM_LAT, go to WAIT.
- WAIT: decrement the counter; at 0, register mem_rdata_i into the owner's rdata_o, pulse the owner's rvalid_o next cycle, go to IDLE.
REQ-021 At most one gnt SHALL be high in any cycle, and only in IDLE; gnt SHALL never assert outside IDLE.
REQ-022 Request-to-rvalid latency SHALL be MEM_LAT+2 cycles.
REQ-023 The rvalid cycle SHALL coincide with IDLE, so a new grant can occur in the rvalid cycle (back-to-back throughput of one access per MEM_LAT+2 cycles).
REQ-024 Data writes SHALL pulse d_rvalid_o at the same latency as reads; d_rdata_o SHALL hold its previous value.
REQ-025 Requests SHALL be ignored outside IDLE; a request dropped before grant is legal and SHALL have no effect.
REQ-026 Without MEM_ARB_RR_EN, simultaneous requests SHALL grant the data port (fixed priority).
REQ-027 mem_addr_o, mem_wdata_o and mem_be_o SHALL hold the last issued command until the next ISSUE.
REQ-028 Fetch accesses SHALL drive mem_be_o = 4'hF and mem_wdata_o = 0.

Reset
REQ-029 On rst, the block SHALL enter IDLE with counter = 0.
REQ-030 On rst, all gnt, rvalid and mem strobe outputs SHALL be 0, and all 32-bit outputs and mem_be_o SHALL be 0.
REQ-031 Reset asserted mid-access SHALL abandon the access; no rvalid for it SHALL ever be produced.

Configuration
REQ-032 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be arbitrated round-robin.
- A last-grant flag selects the winner: the port not granted last wins.
- Reset value: last-grant = fetch, so the first tie goes to data.
- The flag updates only on a grant.
- Without the macro, no flag exists and REQ-026 applies.

Verification (MEM_LAT=2)
REQ-033 Fetch read: if_req_i=1, addr 0x100 at T0 -> if_gnt_o at T0, mem_re_o with mem_addr_o=0x100 at T1, mem_rdata_i=0xDEADBEEF at T3 -> if_rvalid_o with if_rdata_o=0xDEADBEEF at T4.
REQ-034 Data write: addr 0x200, wdata 0x12345678, be 4'b0011 -> mem_we_o with matching bus at T1, d_rvalid_o at T4, d_rdata_o unchanged.
REQ-035 Simultaneous requests, three times:
- Without the macro: grant order data, data, data.
- With MEM_ARB_RR_EN: grant order data, fetch, data.
REQ-036 Continuous fetch requests -> grants at T0, T4, T8; no gap beyond MEM_LAT+2.
REQ-037 rst asserted at T2 of a read -> all outputs 0 at T3, no rvalid ever; a fresh request at T4 is granted normally.
REQ-038 d_req_i pulsed during WAIT only -> no d_gnt_o, no memory strobe.
